// File: rtl/wb_regfile.sv
// Y86-64 writeback stage and architectural register file.
// Commits valE/valM from the W stage into 15 program registers. Provides
// combinational read ports for decode and for debug. Holds the sticky
// program status and the retired-instruction counter.
module wb_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val,
    output logic [2:0]  prog_stat,
    output logic        halted,
    output logic [63:0] retired
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    logic [2:0]  stat_reg;
    logic [2:0]  stat_next;
    logic [63:0] retired_reg;
    logic [63:0] retired_next;
    logic        we;

    // Register contents gathered into one array. Slot 15 is the constant-zero "no register" slot.
    logic [63:0] reg_view [0:15];

    // The retire rule depends only on the status code, so the icode is not used.
    logic unused_icode;
    assign unused_icode = ^W_icode;

    // Writes are gated by the pre-edge status. A faulting or halting instruction never commits.
    assign we = (stat_reg == STAT_AOK) && (W_stat == STAT_AOK);

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : gen_reg
            localparam logic [3:0]  IDX  = 4'(gi);
            localparam logic [63:0] INIT = (gi == 4) ? RSP_INIT : 64'd0;

            logic [63:0] val_reg;
            logic [63:0] val_next;

            // Select this register's next value. valM has priority over valE, so popq %rsp loads the popped value.
            always_comb begin
                val_next = val_reg;
                if (we && (W_dstM == IDX)) begin
                    val_next = W_valM;
                end else if (we && (W_dstE == IDX)) begin
                    val_next = W_valE;
                end
            end

            // Register storage. Async reset to zero, or to RSP_INIT for %rsp.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= INIT;
                end else begin
                    val_reg <= val_next;
                end
            end

            assign reg_view[gi] = val_reg;
        end
    endgenerate

    assign reg_view[15] = 64'd0;

    // Status update and retire count. Both freeze once the status leaves AOK.
    always_comb begin
        stat_next    = stat_reg;
        retired_next = retired_reg;
        if (stat_reg == STAT_AOK) begin
            case (W_stat)
                STAT_AOK: begin
                    retired_next = retired_reg + 64'd1;
                end
                STAT_HLT: begin
                    stat_next    = STAT_HLT;
                    retired_next = retired_reg + 64'd1;
                end
                STAT_ADR, STAT_INS: begin
                    stat_next = W_stat;
                end
                default: begin
                    // BUB and undefined codes behave as bubbles
                end
            endcase
        end
    end

    // Status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reg    <= STAT_AOK;
            retired_reg <= 64'd0;
        end else begin
            stat_reg    <= stat_next;
            retired_reg <= retired_next;
        end
    end

    // Combinational reads with no forwarding. Decode handles bypass from W.
    assign d_rvalA   = reg_view[d_srcA];
    assign d_rvalB   = reg_view[d_srcB];
    assign dbg_val   = reg_view[dbg_sel];
    assign prog_stat = stat_reg;
    assign halted    = (stat_reg != STAT_AOK);
    assign retired   = retired_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed W-stage transactions, a reference
// model of the register file, status and counter, and a per-cycle compare.
module tb_wb_regfile;

    localparam logic [63:0] RSP_VAL = 64'h100;
    localparam logic [2:0]  BUB = 3'd0;
    localparam logic [2:0]  AOK = 3'd1;
    localparam logic [2:0]  HLT = 3'd2;
    localparam logic [2:0]  ADR = 3'd3;
    localparam logic [2:0]  INS = 3'd4;
    localparam logic [3:0]  RNONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;
    logic [2:0]  prog_stat;
    logic        halted;
    logic [63:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regfile #(.RSP_INIT(RSP_VAL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .dbg_sel  (dbg_sel),
        .dbg_val  (dbg_val),
        .prog_stat(prog_stat),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as plain variables.
    logic [63:0] m_reg [0:14];
    logic [2:0]  m_stat = AOK;
    logic [63:0] m_ret  = 64'd0;

    function automatic logic [63:0] m_read(input logic [3:0] sel);
        if (sel == RNONE) return 64'd0;
        return m_reg[sel];
    endfunction

    // Model update: reset, or commit the instruction in W.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? RSP_VAL : 64'd0;
            m_stat = AOK;
            m_ret  = 64'd0;
        end else if (m_stat == AOK) begin
            if (W_stat == AOK) begin
                if (W_dstE != RNONE) m_reg[W_dstE] = W_valE;
                if (W_dstM != RNONE) m_reg[W_dstM] = W_valM;  // M after E: M wins
                m_ret = m_ret + 1;
            end else if (W_stat == HLT) begin
                m_stat = HLT;
                m_ret  = m_ret + 1;
            end else if (W_stat == ADR || W_stat == INS) begin
                m_stat = W_stat;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        check("cyc_rvalA",   d_rvalA,          m_read(d_srcA));
        check("cyc_rvalB",   d_rvalB,          m_read(d_srcB));
        check("cyc_dbg",     dbg_val,          m_read(dbg_sel));
        check("cyc_stat",    64'(prog_stat),   64'(m_stat));
        check("cyc_halted",  64'(halted),      64'(m_stat != AOK));
        check("cyc_retired", retired,          m_ret);
    end

    task automatic idle();
        W_stat  = BUB;
        W_icode = 4'h1;
        W_valE  = 64'd0;
        W_valM  = 64'd0;
        W_dstE  = RNONE;
        W_dstM  = RNONE;
    endtask

    // Present one instruction in W for one edge, then return to a bubble.
    task automatic issue(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        @(posedge clk);
        #2;
        W_stat = st;
        W_dstE = de;
        W_valE = ve;
        W_dstM = dm;
        W_valM = vm;
        @(posedge clk);
        #2;
        idle();
        $display("txn stat=%0d dstE=%h valE=%h dstM=%h valM=%h -> prog_stat=%0d retired=%0d",
                 st, de, ve, dm, vm, prog_stat, retired);
    endtask

    // Literal debug-port read check, done clear of clock edges.
    task automatic peek(input logic [3:0] sel, input logic [63:0] exp, input string name);
        @(posedge clk);
        #2;
        dbg_sel = sel;
        #1;
        check(name, dbg_val, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        idle();
        d_srcA  = RNONE;
        d_srcB  = RNONE;
        dbg_sel = RNONE;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_stat",    64'(prog_stat), 64'd1);
        check("rst_halted",  64'(halted),    64'd0);
        check("rst_retired", retired,        64'd0);
        check("rst_srcF",    d_rvalA,        64'd0);
        for (int i = 0; i < 15; i++) begin
            peek(4'(i), (i == 4) ? 64'h100 : 64'd0, "rst_reg");
        end

        // Dual write with same-cycle reads returning the old values
        @(posedge clk);
        #2;
        W_stat = AOK; W_dstE = 4'd2; W_valE = 64'd5; W_dstM = 4'd3; W_valM = 64'd9;
        d_srcA = 4'd2;
        d_srcB = 4'd3;
        #1;
        check("dual_old_R2", d_rvalA, 64'd0);
        check("dual_old_R3", d_rvalB, 64'd0);
        @(posedge clk);
        #2;
        idle();
        $display("txn stat=1 dstE=2 valE=5 dstM=3 valM=9 -> prog_stat=%0d retired=%0d", prog_stat, retired);
        check("dual_R2", d_rvalA, 64'd5);
        check("dual_R3", d_rvalB, 64'd9);
        check("dual_retired", retired, 64'd1);

        // Collision on %rsp: valM wins
        issue(AOK, 4'd4, 64'h108, 4'd4, 64'hAA);
        peek(4'd4, 64'hAA, "coll_R4");
        check("coll_retired", retired, 64'd2);

        // Bubble: no write, no count
        issue(BUB, 4'd1, 64'd7, RNONE, 64'd0);
        peek(4'd1, 64'd0, "bub_R1");
        check("bub_retired", retired, 64'd2);

        // Halt: counted, status sticks
        issue(HLT, RNONE, 64'd0, RNONE, 64'd0);
        check("hlt_stat",    64'(prog_stat), 64'd2);
        check("hlt_halted",  64'(halted),    64'd1);
        check("hlt_retired", retired,        64'd3);

        // AOK after halt: ignored
        issue(AOK, 4'd1, 64'd7, RNONE, 64'd0);
        peek(4'd1, 64'd0, "posthlt_R1");
        check("posthlt_retired", retired, 64'd3);

        // Asynchronous reset between edges
        dbg_sel = 4'd4;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_stat",    64'(prog_stat), 64'd1);
        check("arst_halted",  64'(halted),    64'd0);
        check("arst_retired", retired,        64'd0);
        check("arst_R4",      dbg_val,        64'h100);
        check("arst_R2",      d_rvalA,        64'd0);
        rst_n = 1'b1;

        issue(AOK, 4'd6, 64'h66, RNONE, 64'd0);
        peek(4'd6, 64'h66, "arst_R6");
        check("arst_w_retired", retired, 64'd1);

        // Address exception: no write, no count
        issue(ADR, RNONE, 64'd0, 4'd5, 64'd3);
        peek(4'd5, 64'd0, "adr_R5");
        check("adr_stat",    64'(prog_stat), 64'd3);
        check("adr_halted",  64'(halted),    64'd1);
        check("adr_retired", retired,        64'd1);

        // Later INS does not overwrite the sticky status
        issue(INS, RNONE, 64'd0, RNONE, 64'd0);
        check("ins_stat",    64'(prog_stat), 64'd3);
        check("ins_retired", retired,        64'd1);

        // An edge with reset held low performs no write
        @(posedge clk);
        #2;
        W_stat = AOK; W_dstE = 4'd7; W_valE = 64'h77;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle();
        peek(4'd7, 64'd0, "rstedge_R7");
        check("rstedge_retired", retired, 64'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
